// File: rtl/dcache_2way_pkg.sv
// Shared definitions for the 2-way write-back data cache: geometry, FSM states
// and the byte-merge helper used for stores on both the hit and refill paths.
package dcache_2way_pkg;
   localparam int INDEX_W  = 8;
   localparam int OFFSET_W = 4;
   localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
   localparam int SETS     = 1 << INDEX_W;
   localparam int LINE_W   = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WB,
      ST_REFILL,
      ST_DONE
   } state_t;

   function automatic logic [LINE_W-1:0] merge_line(
      input logic [LINE_W-1:0] line,
      input logic [1:0]        word_idx,
      input logic [31:0]       wdata,
      input logic [3:0]        sel
   );
      logic [LINE_W-1:0] res;
      res = line;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[int'({word_idx, 5'b0}) + b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction
endpackage

// File: rtl/dcache_2way_way.sv
// One way of the cache: tag/data arrays with asynchronous read and a single
// synchronous line write port; valid/dirty bits are the only reset state.
module dcache_2way_way
   import dcache_2way_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [INDEX_W-1:0] index,
   input  logic [TAG_W-1:0]  cmp_tag,
   input  logic              wr_en,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              wr_dirty,
   output logic              hit,
   output logic              valid,
   output logic              dirty,
   output logic [TAG_W-1:0]  tag,
   output logic [LINE_W-1:0] line
);
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] data_mem [SETS];
   logic [SETS-1:0]   valid_bits;
   logic [SETS-1:0]   dirty_bits;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[index]  <= wr_tag;
         data_mem[index] <= wr_line;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (wr_en) begin
         valid_bits[index] <= 1'b1;
         dirty_bits[index] <= wr_dirty;
      end
   end

   assign valid = valid_bits[index];
   assign dirty = dirty_bits[index];
   assign tag   = tag_mem[index];
   assign line  = data_mem[index];
   assign hit   = valid && (tag == cmp_tag);
endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back data cache between the CPU data port and a
// 128-bit line memory; hits complete in one cycle, misses stall the CPU.
//
// state  | meaning
// IDLE   | accept CPU request; hits served here, misses captured
// WB     | writing the dirty victim line back to memory
// REFILL | fetching the requested line into the victim way
// DONE   | miss completed: data_ok pulse, LRU update
module dcache_2way
   import dcache_2way_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   input  logic              cpu_wreq_i,
   input  logic              cpu_rreq_i,
   input  logic [3:0]        cpu_sel_i,
   output logic [31:0]       dcache_data_o,
   output logic              stallreq_o,
   output logic              data_ok_o,
   output logic              mem_rreq_o,
   output logic [31:0]       mem_raddr_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_rvalid_i,
   output logic              mem_wreq_o,
   output logic [31:0]       mem_waddr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_wready_i
);
   state_t             state, state_nxt;
   logic [31:2]        cap_addr;
   logic [31:0]        cap_wdata;
   logic [3:0]         cap_sel;
   logic               cap_store;
   logic               cap_way;
   logic [SETS-1:0]    lru;
   logic               data_ok_q;
   logic [31:0]        rdata_q;

   logic               cpu_req, cpu_store;
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   cpu_tag;
   logic [1:0]         way_hit, way_valid, way_dirty, way_we;
   logic [TAG_W-1:0]   way_tag  [2];
   logic [LINE_W-1:0]  way_line [2];
   logic               hit_any, hit_way, victim_way;
   logic [LINE_W-1:0]  hit_line, refill_line;
   logic [31:0]        hit_word;
   logic [TAG_W-1:0]   wr_tag;
   logic [LINE_W-1:0]  wr_line;
   logic               wr_dirty;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr_i[1:0];
   assign cpu_req   = cpu_rreq_i | cpu_wreq_i;
   assign cpu_store = cpu_wreq_i;
   assign cpu_tag   = cpu_addr_i[31:INDEX_W+4];
   assign index     = (state == ST_IDLE) ? cpu_addr_i[INDEX_W+3:4] : cap_addr[INDEX_W+3:4];

   dcache_2way_way u_way0 (
      .clk(clk), .rst(rst), .index(index), .cmp_tag(cpu_tag),
      .wr_en(way_we[0]), .wr_tag(wr_tag), .wr_line(wr_line), .wr_dirty(wr_dirty),
      .hit(way_hit[0]), .valid(way_valid[0]), .dirty(way_dirty[0]),
      .tag(way_tag[0]), .line(way_line[0])
   );

   dcache_2way_way u_way1 (
      .clk(clk), .rst(rst), .index(index), .cmp_tag(cpu_tag),
      .wr_en(way_we[1]), .wr_tag(wr_tag), .wr_line(wr_line), .wr_dirty(wr_dirty),
      .hit(way_hit[1]), .valid(way_valid[1]), .dirty(way_dirty[1]),
      .tag(way_tag[1]), .line(way_line[1])
   );

   assign hit_any    = |way_hit;
   assign hit_way    = way_hit[1];
   assign hit_line   = way_line[hit_way];
   assign hit_word   = hit_line[{cpu_addr_i[3:2], 5'b0} +: 32];
   // Invalid ways are filled before anything valid is evicted.
   assign victim_way = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[index]);
   assign refill_line = cap_store ? merge_line(mem_rdata_i, cap_addr[3:2], cap_wdata, cap_sel)
                                  : mem_rdata_i;

   always_comb begin
      state_nxt = state;
      way_we    = '0;
      wr_tag    = cap_addr[31:INDEX_W+4];
      wr_line   = refill_line;
      wr_dirty  = cap_store;
      case (state)
         ST_IDLE: begin
            if (cpu_req) begin
               if (hit_any) begin
                  way_we[hit_way] = cpu_store;
                  wr_tag          = cpu_tag;
                  wr_line         = merge_line(hit_line, cpu_addr_i[3:2], cpu_wdata_i, cpu_sel_i);
                  wr_dirty        = 1'b1;
               end else if (way_valid[victim_way] && way_dirty[victim_way]) begin
                  state_nxt = ST_WB;
               end else begin
                  state_nxt = ST_REFILL;
               end
            end
         end
         ST_WB:     if (mem_wready_i) state_nxt = ST_REFILL;
         ST_REFILL: begin
            if (mem_rvalid_i) begin
               way_we[cap_way] = 1'b1;
               state_nxt       = ST_DONE;
            end
         end
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_sel   <= '0;
         cap_store <= 1'b0;
         cap_way   <= 1'b0;
         lru       <= '0;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state     <= state_nxt;
         data_ok_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req && hit_any) begin
                  data_ok_q  <= 1'b1;
                  lru[index] <= ~hit_way;
                  if (!cpu_store) rdata_q <= hit_word;
               end else if (cpu_req) begin
                  cap_addr  <= cpu_addr_i[31:2];
                  cap_wdata <= cpu_wdata_i;
                  cap_sel   <= cpu_sel_i;
                  cap_store <= cpu_store;
                  cap_way   <= victim_way;
               end
            end
            ST_REFILL: if (mem_rvalid_i) rdata_q <= refill_line[{cap_addr[3:2], 5'b0} +: 32];
            ST_DONE:   lru[index] <= ~cap_way;
            default:   ;
         endcase
      end
   end

   assign dcache_data_o = rdata_q;
   assign data_ok_o     = data_ok_q | (state == ST_DONE);
   // Gated by rst so a request held through reset cannot raise a stall.
   assign stallreq_o    = rst & ((state != ST_IDLE) | (cpu_req & ~hit_any));
   assign mem_wreq_o    = (state == ST_WB);
   assign mem_waddr_o   = (state == ST_WB) ? {way_tag[cap_way], cap_addr[INDEX_W+3:4], 4'b0} : '0;
   assign mem_wdata_o   = (state == ST_WB) ? way_line[cap_way] : '0;
   assign mem_rreq_o    = (state == ST_REFILL);
   assign mem_raddr_o   = (state == ST_REFILL) ? {cap_addr[31:4], 4'b0} : '0;
endmodule
